// File: rtl/sine_nco_core.sv
// Sine NCO: phase accumulator, 64-entry quarter-wave ROM with quadrant folding,
// and a two-stage registered output with valid and wrap strobes.
module sine_nco_core #(
  parameter int unsigned ACC_W   = 16,
  parameter int unsigned FCW_RST = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [ACC_W-1:0] fcw_in,
  input  logic             fcw_wr,
  input  logic             phase_clr,
  output logic [7:0]       sample_out,
  output logic             sample_valid,
  output logic             phase_wrap
);

  localparam int unsigned AMP_W = 7;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] fcw;
  logic [ACC_W:0]   sum;
  logic [7:0]       phase;
  logic [5:0]       idx;
  logic [AMP_W-1:0] rom_amp;
  logic [AMP_W-1:0] amp;
  logic             neg;
  logic             v1;
  logic             wrap1;

  // Next phase with carry; odd quadrants read the quarter table mirrored
  always_comb begin
    sum   = {1'b0, acc} + {1'b0, fcw};
    phase = acc[ACC_W-1 -: 8];
    idx   = phase[6] ? ~phase[5:0] : phase[5:0];
  end

  // round(127*sin(pi/2*(k+0.5)/64)), k = 0..63
  always_comb begin
    rom_amp = 7'd127;
    case (idx)
      6'd0:  rom_amp = 7'd2;   6'd1:  rom_amp = 7'd5;   6'd2:  rom_amp = 7'd8;   6'd3:  rom_amp = 7'd11;
      6'd4:  rom_amp = 7'd14;  6'd5:  rom_amp = 7'd17;  6'd6:  rom_amp = 7'd20;  6'd7:  rom_amp = 7'd23;
      6'd8:  rom_amp = 7'd26;  6'd9:  rom_amp = 7'd29;  6'd10: rom_amp = 7'd32;  6'd11: rom_amp = 7'd35;
      6'd12: rom_amp = 7'd38;  6'd13: rom_amp = 7'd41;  6'd14: rom_amp = 7'd44;  6'd15: rom_amp = 7'd47;
      6'd16: rom_amp = 7'd50;  6'd17: rom_amp = 7'd53;  6'd18: rom_amp = 7'd56;  6'd19: rom_amp = 7'd58;
      6'd20: rom_amp = 7'd61;  6'd21: rom_amp = 7'd64;  6'd22: rom_amp = 7'd67;  6'd23: rom_amp = 7'd69;
      6'd24: rom_amp = 7'd72;  6'd25: rom_amp = 7'd74;  6'd26: rom_amp = 7'd77;  6'd27: rom_amp = 7'd79;
      6'd28: rom_amp = 7'd82;  6'd29: rom_amp = 7'd84;  6'd30: rom_amp = 7'd86;  6'd31: rom_amp = 7'd89;
      6'd32: rom_amp = 7'd91;  6'd33: rom_amp = 7'd93;  6'd34: rom_amp = 7'd95;  6'd35: rom_amp = 7'd97;
      6'd36: rom_amp = 7'd99;  6'd37: rom_amp = 7'd101; 6'd38: rom_amp = 7'd103; 6'd39: rom_amp = 7'd105;
      6'd40: rom_amp = 7'd106; 6'd41: rom_amp = 7'd108; 6'd42: rom_amp = 7'd110; 6'd43: rom_amp = 7'd111;
      6'd44: rom_amp = 7'd113; 6'd45: rom_amp = 7'd114; 6'd46: rom_amp = 7'd115; 6'd47: rom_amp = 7'd117;
      6'd48: rom_amp = 7'd118; 6'd49: rom_amp = 7'd119; 6'd50: rom_amp = 7'd120; 6'd51: rom_amp = 7'd121;
      6'd52: rom_amp = 7'd122; 6'd53: rom_amp = 7'd123; 6'd54: rom_amp = 7'd124; 6'd55: rom_amp = 7'd124;
      6'd56: rom_amp = 7'd125; 6'd57: rom_amp = 7'd125; 6'd58: rom_amp = 7'd126; 6'd59: rom_amp = 7'd126;
      6'd60: rom_amp = 7'd127; 6'd61: rom_amp = 7'd127; 6'd62: rom_amp = 7'd127; 6'd63: rom_amp = 7'd127;
      default: rom_amp = 7'd127;
    endcase
  end

  // Phase accumulator; a same-edge FCW write only affects later increments
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
      fcw <= ACC_W'(FCW_RST);
    end else begin
      if (fcw_wr) fcw <= fcw_in;
      if (phase_clr)  acc <= '0;
      else if (en)    acc <= sum[ACC_W-1:0];
    end
  end

  // Stage 1: table lookup on the pre-increment phase
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      wrap1 <= 1'b0;
      amp   <= '0;
      neg   <= 1'b0;
    end else begin
      v1 <= en;
      if (en) begin
        amp   <= rom_amp;
        neg   <= phase[7];
        wrap1 <= sum[ACC_W];
      end
    end
  end

  // Stage 2: offset-binary output, held between valid samples
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_out   <= 8'd128;
      sample_valid <= 1'b0;
      phase_wrap   <= 1'b0;
    end else begin
      sample_valid <= v1;
      phase_wrap   <= v1 & wrap1;
      if (v1) sample_out <= neg ? 8'(7'd127 - amp) : 8'(8'd128 + 8'(amp));
    end
  end

endmodule

// File: tb/tb_sine_nco_core.sv
// Bench for sine_nco_core: randomized and directed stimulus against a
// phase-domain reference model using real-valued sine.
module tb_sine_nco_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] fcw_in = 16'd0;
  logic        fcw_wr = 1'b0;
  logic        phase_clr = 1'b0;
  logic [7:0]  sample_out;
  logic        sample_valid;
  logic        phase_wrap;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int       m_acc = 0;
  int       m_fcw = 256;
  bit       pend_v = 0;
  int       pend_s = 128;
  bit       pend_w = 0;
  logic [7:0] e_out = 8'd128;
  bit       e_v = 0;
  bit       e_w = 0;

  sine_nco_core #(.ACC_W(16), .FCW_RST(256)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .fcw_in(fcw_in), .fcw_wr(fcw_wr),
    .phase_clr(phase_clr), .sample_out(sample_out), .sample_valid(sample_valid),
    .phase_wrap(phase_wrap)
  );

  always #5 clk = ~clk;

  function automatic int ref_sample(int p);
    int q, i, k, a;
    q = p / 64;
    i = p % 64;
    k = (q % 2 == 1) ? 63 - i : i;
    a = $rtoi(127.0 * $sin(3.14159265358979 * (real'(k) + 0.5) / 128.0) + 0.5);
    return (q >= 2) ? 127 - a : 128 + a;
  endfunction

  // advance one edge and update the expected outputs
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_acc = 0; m_fcw = 256; pend_v = 0; e_v = 0; e_w = 0; e_out = 8'd128;
    end else begin
      e_v = pend_v;
      e_w = pend_v && pend_w;
      if (pend_v) e_out = 8'(pend_s);
      if (en) begin
        pend_v = 1;
        pend_s = ref_sample(m_acc / 256);
        pend_w = (m_acc + m_fcw) >= 65536;
      end else pend_v = 0;
      if (phase_clr)  m_acc = 0;
      else if (en)    m_acc = (m_acc + m_fcw) % 65536;
      if (fcw_wr) m_fcw = int'(fcw_in);
    end
    #1;
  endtask

  task automatic prep(input logic [15:0] f);
    rst_n = 1'b1; en = 1'b0; fcw_wr = 1'b1; fcw_in = f; phase_clr = 1'b1;
    tick();
    fcw_wr = 1'b0; phase_clr = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    int nv = 0, nw = 0;
    rst_n = 1'b0; en = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if ({sample_valid, phase_wrap, sample_out} !== {1'b0, 1'b0, 8'd128}) begin
        n_fail++;
        $display("FAIL reset_state: got v=%0b w=%0b out=%0d, want v=0 w=0 out=128", sample_valid, phase_wrap, sample_out);
      end
    end
    rst_n = 1'b1; en = 1'b1;
    for (int c = 0; c < 300; c++) begin
      tick();
      n_checks++;
      if ({sample_valid, phase_wrap, sample_out} !== {e_v, e_w, e_out}) begin
        n_fail++;
        $display("FAIL default_stream c=%0d: got v=%0b w=%0b out=%0d, want v=%0b w=%0b out=%0d", c, sample_valid, phase_wrap, sample_out, e_v, e_w, e_out);
      end
      if (c == 1) begin
        n_checks++;
        if ({sample_valid, sample_out} !== {1'b1, 8'd130}) begin
          n_fail++;
          $display("FAIL first_latency: got v=%0b out=%0d, want v=1 out=130", sample_valid, sample_out);
        end
      end
      if (sample_valid && nv < 256) begin
        if (nv == 64 || nv == 128 || nv == 192) begin
          n_checks++;
          if (sample_out !== ((nv == 64) ? 8'd255 : (nv == 128) ? 8'd125 : 8'd0)) begin
            n_fail++;
            $display("FAIL quadrant_point p=%0d: got %0d", nv, sample_out);
          end
        end
        if (phase_wrap) nw++;
        nv++;
      end
    end
    n_checks++;
    if (nw != 1) begin
      n_fail++;
      $display("FAIL wrap_count: got %0d wraps in 256 samples, want 1", nw);
    end
  endtask

  task automatic test_quarter_rate();
    int pat[4] = '{130, 255, 125, 0};
    int n = 0;
    prep(16'd16384);
    en = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      n_checks++;
      if ({sample_valid, phase_wrap, sample_out} !== {e_v, e_w, e_out}) begin
        n_fail++;
        $display("FAIL quarter_model c=%0d: got v=%0b w=%0b out=%0d, want v=%0b w=%0b out=%0d", c, sample_valid, phase_wrap, sample_out, e_v, e_w, e_out);
      end
      if (sample_valid) begin
        n_checks++;
        if ({phase_wrap, sample_out} !== {(n % 4 == 3), 8'(pat[n % 4])}) begin
          n_fail++;
          $display("FAIL quarter_pattern n=%0d: got w=%0b out=%0d, want w=%0b out=%0d", n, phase_wrap, sample_out, (n % 4 == 3), pat[n % 4]);
        end
        n++;
      end
    end
    en = 1'b0;
  endtask

  task automatic test_enable_gating();
    bit seq[7] = '{1, 0, 0, 1, 0, 0, 0};
    int vals[2] = '{130, 255};
    int nv = 0;
    prep(16'd16384);
    for (int c = 0; c < 7; c++) begin
      en = seq[c];
      tick();
      n_checks++;
      if ({sample_valid, phase_wrap, sample_out} !== {e_v, e_w, e_out}) begin
        n_fail++;
        $display("FAIL gating_model c=%0d: got v=%0b out=%0d, want v=%0b out=%0d", c, sample_valid, sample_out, e_v, e_out);
      end
      if (c == 2 || c == 3) begin
        n_checks++;
        if ({sample_valid, sample_out} !== {1'b0, 8'd130}) begin
          n_fail++;
          $display("FAIL gating_hold c=%0d: got v=%0b out=%0d, want v=0 out=130", c, sample_valid, sample_out);
        end
      end
      if (sample_valid) begin
        if (nv < 2) begin
          n_checks++;
          if (sample_out !== 8'(vals[nv])) begin
            n_fail++;
            $display("FAIL gating_value %0d: got %0d, want %0d", nv, sample_out, vals[nv]);
          end
        end
        nv++;
      end
    end
    n_checks++;
    if (nv != 2) begin
      n_fail++;
      $display("FAIL gating_count: got %0d pulses, want 2", nv);
    end
  endtask

  // directed sequence helper for the collision and phase-clear cases
  task automatic run_directed(input bit do_clr, input int want[5]);
    int nv = 0;
    prep(16'd16384);
    en = 1'b1;
    for (int c = 0; c < 6; c++) begin
      fcw_wr = (!do_clr && c == 1);
      fcw_in = 16'd32768;
      phase_clr = (do_clr && c == 2);
      tick();
      n_checks++;
      if ({sample_valid, phase_wrap, sample_out} !== {e_v, e_w, e_out}) begin
        n_fail++;
        $display("FAIL directed_model clr=%0b c=%0d: got v=%0b w=%0b out=%0d, want v=%0b w=%0b out=%0d", do_clr, c, sample_valid, phase_wrap, sample_out, e_v, e_w, e_out);
      end
      if (sample_valid && nv < 5) begin
        n_checks++;
        if (sample_out !== 8'(want[nv])) begin
          n_fail++;
          $display("FAIL directed_value clr=%0b n=%0d: got %0d, want %0d", do_clr, nv, sample_out, want[nv]);
        end
        nv++;
      end
    end
    en = 1'b0; fcw_wr = 1'b0; phase_clr = 1'b0;
  endtask

  task automatic test_fcw_collision();
    run_directed(1'b0, '{130, 255, 125, 130, 125});
  endtask

  task automatic test_phase_clear();
    run_directed(1'b1, '{130, 255, 125, 130, 255});
  endtask

  task automatic test_fcw_zero();
    prep(16'd0);
    en = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (c >= 1) begin
        n_checks++;
        if ({sample_valid, phase_wrap, sample_out} !== {1'b1, 1'b0, 8'd130}) begin
          n_fail++;
          $display("FAIL fcw_zero c=%0d: got v=%0b w=%0b out=%0d, want v=1 w=0 out=130", c, sample_valid, phase_wrap, sample_out);
        end
      end
    end
    en = 1'b0;
  endtask

  task automatic test_reset_mid_and_sweep();
    int s[256];
    int nv = 0;
    prep(16'd4096);
    en = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    n_checks++;
    if ({sample_valid, phase_wrap, sample_out} !== {1'b0, 1'b0, 8'd128}) begin
      n_fail++;
      $display("FAIL reset_mid: got v=%0b w=%0b out=%0d, want v=0 w=0 out=128", sample_valid, phase_wrap, sample_out);
    end
    rst_n = 1'b1; en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if ({sample_valid, phase_wrap, sample_out} !== {1'b0, 1'b0, 8'd128}) begin
        n_fail++;
        $display("FAIL no_stale c=%0d: got v=%0b w=%0b out=%0d, want v=0 w=0 out=128", c, sample_valid, phase_wrap, sample_out);
      end
    end
    en = 1'b1;
    for (int c = 0; c < 258; c++) begin
      tick();
      if (sample_valid && nv < 256) begin
        s[nv] = int'(sample_out);
        nv++;
      end
    end
    en = 1'b0;
    n_checks++;
    if (nv != 256) begin
      n_fail++;
      $display("FAIL sweep_count: got %0d samples, want 256", nv);
    end
    for (int p = 0; p < 256; p++) begin
      n_checks++;
      if (s[p] != ref_sample(p)) begin
        n_fail++;
        $display("FAIL sweep_value p=%0d: got %0d, want %0d", p, s[p], ref_sample(p));
      end
    end
    for (int p = 0; p < 128; p++) begin
      n_checks++;
      if (s[p] + s[p + 128] != 255) begin
        n_fail++;
        $display("FAIL symmetry p=%0d: got %0d+%0d, want sum 255", p, s[p], s[p + 128]);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      en        = ($urandom % 4) != 0;
      fcw_wr    = ($urandom % 16) == 0;
      fcw_in    = 16'($urandom);
      phase_clr = ($urandom % 32) == 0;
      tick();
      n_checks++;
      if ({sample_valid, phase_wrap, sample_out} !== {e_v, e_w, e_out}) begin
        n_fail++;
        $display("FAIL random c=%0d: got v=%0b w=%0b out=%0d, want v=%0b w=%0b out=%0d", c, sample_valid, phase_wrap, sample_out, e_v, e_w, e_out);
      end
    end
    en = 1'b0; fcw_wr = 1'b0; phase_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_quarter_rate();
    test_enable_gating();
    test_fcw_collision();
    test_phase_clear();
    test_fcw_zero();
    test_reset_mid_and_sweep();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
